// File: rtl/gemm_tile_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// gemm_pkg
// Shared definitions for the 4x4 int8 systolic GEMM tile sequencer.
// Holds the sequencer state encoding and the array geometry constants that
// both the top-level FSM and the tile address generator rely on.
// No ports; imported with "import gemm_pkg::*".
// ---------------------------------------------------------------------------
package gemm_pkg;

    localparam int ARRAY_DIM      = 4;

    // One cycle to absorb the last word's read latency, then 2*(ARRAY_DIM-1)
    // zero injections to push the skewed wavefront out of the array.
    localparam int FLUSH_CYCLES   = 7;
    localparam int FLUSH_CNT_BITS = 3;

    localparam int OUT_IDX_BITS   = 4;
    localparam int OUT_IDX_LAST   = ARRAY_DIM * ARRAY_DIM - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/gemm_tile_sequencer_tile_addr_gen.sv
// ---------------------------------------------------------------------------
// tile_addr_gen
// Address bookkeeping for the GEMM tile walk. Keeps the K-step counter kc,
// the tile coordinates mb/nb and running A/B base registers so that
//   a_addr = mb*cfg_k + kc,   b_addr = nb*cfg_k + kc
// is formed with adders only. Overflow wraps silently.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_m_i/n_i/k_i     latched job dimensions
//   init_i              start of a job: zero tile coordinates and bases
//   clear_i             start of a tile: zero kc
//   step_i              one FEED cycle: advance kc
//   next_tile_i         tile drained and not the last one: move to next tile
//   a_addr_o, b_addr_o  buffer read indices
//   mb_o, nb_o          current tile coordinates
//   last_k_o            kc is on the final reduction step
//   last_tile_o         current tile is the final tile of the job
// ---------------------------------------------------------------------------
module tile_addr_gen #(
    parameter int A_ADDR_BITS = 16,
    parameter int B_ADDR_BITS = 14,
    parameter int DIM_BITS    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIM_BITS-1:0]    cfg_m_i,
    input  logic [DIM_BITS-1:0]    cfg_n_i,
    input  logic [DIM_BITS-1:0]    cfg_k_i,
    input  logic                   init_i,
    input  logic                   clear_i,
    input  logic                   step_i,
    input  logic                   next_tile_i,
    output logic [A_ADDR_BITS-1:0] a_addr_o,
    output logic [B_ADDR_BITS-1:0] b_addr_o,
    output logic [DIM_BITS-1:0]    mb_o,
    output logic [DIM_BITS-1:0]    nb_o,
    output logic                   last_k_o,
    output logic                   last_tile_o
);

    localparam logic [DIM_BITS-1:0] DIM_ONE = DIM_BITS'(1);

    logic [DIM_BITS-1:0]    kc_q, kc_d;
    logic [DIM_BITS-1:0]    mb_q, mb_d;
    logic [DIM_BITS-1:0]    nb_q, nb_d;
    logic [A_ADDR_BITS-1:0] aBase_q, aBase_d;
    logic [B_ADDR_BITS-1:0] bBase_q, bBase_d;
    logic                   lastN;
    logic                   lastM;

    assign lastN       = (nb_q == cfg_n_i - DIM_ONE);
    assign lastM       = (mb_q == cfg_m_i - DIM_ONE);
    assign last_k_o    = (kc_q == cfg_k_i - DIM_ONE);
    assign last_tile_o = lastN && lastM;

    assign a_addr_o = aBase_q + A_ADDR_BITS'(kc_q);
    assign b_addr_o = bBase_q + B_ADDR_BITS'(kc_q);
    assign mb_o     = mb_q;
    assign nb_o     = nb_q;

    // Next-state for the counters. The tile walk is row-major over (mb, nb):
    // the B base steps by cfg_k along a row and rewinds to zero when the row
    // wraps, at which point the A base steps by cfg_k instead.
    always_comb begin
        kc_d    = kc_q;
        mb_d    = mb_q;
        nb_d    = nb_q;
        aBase_d = aBase_q;
        bBase_d = bBase_q;

        if (clear_i) begin
            kc_d = '0;
        end else if (step_i) begin
            kc_d = kc_q + DIM_ONE;
        end

        if (init_i) begin
            mb_d    = '0;
            nb_d    = '0;
            aBase_d = '0;
            bBase_d = '0;
        end else if (next_tile_i) begin
            if (!lastN) begin
                nb_d    = nb_q + DIM_ONE;
                bBase_d = bBase_q + B_ADDR_BITS'(cfg_k_i);
            end else begin
                nb_d    = '0;
                bBase_d = '0;
                mb_d    = mb_q + DIM_ONE;
                aBase_d = aBase_q + A_ADDR_BITS'(cfg_k_i);
            end
        end
    end

    // Counter registers; everything returns to zero on reset so the address
    // outputs read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kc_q    <= '0;
            mb_q    <= '0;
            nb_q    <= '0;
            aBase_q <= '0;
            bBase_q <= '0;
        end else begin
            kc_q    <= kc_d;
            mb_q    <= mb_d;
            nb_q    <= nb_d;
            aBase_q <= aBase_d;
            bBase_q <= bBase_d;
        end
    end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// ---------------------------------------------------------------------------
// gemm_tile_sequencer
// Control FSM for the 4x4 int8 systolic GEMM datapath. Walks an MxN grid of
// 4x4 output tiles; per tile it clears the accumulators, streams cfg_k A/B
// buffer reads, flushes the skewed array with zeros and drains the 16
// accumulators through a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 job request, only honoured in IDLE
//   cfg_m, cfg_n, cfg_k   tile rows, tile columns, reduction depth
//   busy                  high outside IDLE
//   done                  one-cycle pulse after the last tile drains
//   err                   one-cycle pulse on start with a zero dimension
//   rd_en, a_addr, b_addr global-buffer read strobe and indices
//   acc_clear             clears all accumulators
//   feed_valid, feed_zero array shift enable, and zero-injection select
//   out_valid, out_ready  result handshake
//   out_idx               accumulator index 0..15, row-major
//   out_mb, out_nb        tile coordinates of the tile being drained
// ---------------------------------------------------------------------------
module gemm_tile_sequencer
    import gemm_pkg::*;
#(
    parameter int A_ADDR_BITS = 16,
    parameter int B_ADDR_BITS = 14,
    parameter int DIM_BITS    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DIM_BITS-1:0]     cfg_m,
    input  logic [DIM_BITS-1:0]     cfg_n,
    input  logic [DIM_BITS-1:0]     cfg_k,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    rd_en,
    output logic [A_ADDR_BITS-1:0]  a_addr,
    output logic [B_ADDR_BITS-1:0]  b_addr,
    output logic                    acc_clear,
    output logic                    feed_valid,
    output logic                    feed_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_IDX_BITS-1:0] out_idx,
    output logic [DIM_BITS-1:0]     out_mb,
    output logic [DIM_BITS-1:0]     out_nb
);

    seq_state_e                state_q, state_d;
    logic [DIM_BITS-1:0]       cfgM_q, cfgM_d;
    logic [DIM_BITS-1:0]       cfgN_q, cfgN_d;
    logic [DIM_BITS-1:0]       cfgK_q, cfgK_d;
    logic [FLUSH_CNT_BITS-1:0] flushCnt_q, flushCnt_d;
    logic [OUT_IDX_BITS-1:0]   outIdx_q, outIdx_d;
    logic                      feedDly_q, feedDly_d;

    logic cfgZero;
    logic startAccept;
    logic tileDone;
    logic flushLast;
    logic lastK;
    logic lastTile;
    logic inClear;
    logic inFeed;
    logic nextTile;

    assign cfgZero     = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0);
    assign startAccept = (state_q == ST_IDLE) && start && !cfgZero;
    assign tileDone    = (state_q == ST_DRAIN) && out_ready &&
                         (outIdx_q == OUT_IDX_BITS'(OUT_IDX_LAST));
    assign flushLast   = (flushCnt_q == FLUSH_CNT_BITS'(FLUSH_CYCLES - 1));
    assign inClear     = (state_q == ST_CLEAR);
    assign inFeed      = (state_q == ST_FEED);
    assign nextTile    = tileDone && !lastTile;

    tile_addr_gen #(
        .A_ADDR_BITS (A_ADDR_BITS),
        .B_ADDR_BITS (B_ADDR_BITS),
        .DIM_BITS    (DIM_BITS)
    ) u_tile_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_m_i     (cfgM_q),
        .cfg_n_i     (cfgN_q),
        .cfg_k_i     (cfgK_q),
        .init_i      (startAccept),
        .clear_i     (inClear),
        .step_i      (inFeed),
        .next_tile_i (nextTile),
        .a_addr_o    (a_addr),
        .b_addr_o    (b_addr),
        .mb_o        (out_mb),
        .nb_o        (out_nb),
        .last_k_o    (lastK),
        .last_tile_o (lastTile)
    );

    // State register; reset drops straight back to IDLE, abandoning any job
    // in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A start with any zero dimension is rejected in IDLE;
    // a start in any other state is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (startAccept) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (lastK) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flushLast) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tileDone) begin
                    state_d = lastTile ? ST_DONE : ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode. Buffer data lags the address by one cycle, so the array
    // shift in FEED follows rd_en delayed by a register, and the first FLUSH
    // cycle still shifts real data for the final read.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        err        = (state_q == ST_IDLE) && start && cfgZero;
        rd_en      = (state_q == ST_FEED);
        acc_clear  = (state_q == ST_CLEAR);
        feed_valid = ((state_q == ST_FEED) && feedDly_q) || (state_q == ST_FLUSH);
        feed_zero  = (state_q == ST_FLUSH) && (flushCnt_q != '0);
        out_valid  = (state_q == ST_DRAIN);
    end

    assign out_idx = outIdx_q;

    // Datapath next-state: config is captured only on acceptance, the flush
    // counter runs only inside FLUSH, and the drain index only moves on a
    // completed handshake so it holds under backpressure.
    always_comb begin
        cfgM_d     = cfgM_q;
        cfgN_d     = cfgN_q;
        cfgK_d     = cfgK_q;
        flushCnt_d = '0;
        outIdx_d   = '0;
        feedDly_d  = (state_q == ST_FEED);

        if (startAccept) begin
            cfgM_d = cfg_m;
            cfgN_d = cfg_n;
            cfgK_d = cfg_k;
        end

        if (state_q == ST_FLUSH) begin
            flushCnt_d = flushCnt_q + FLUSH_CNT_BITS'(1);
        end

        if (state_q == ST_DRAIN) begin
            outIdx_d = out_ready ? (outIdx_q + OUT_IDX_BITS'(1)) : outIdx_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfgM_q     <= '0;
            cfgN_q     <= '0;
            cfgK_q     <= '0;
            flushCnt_q <= '0;
            outIdx_q   <= '0;
            feedDly_q  <= 1'b0;
        end else begin
            cfgM_q     <= cfgM_d;
            cfgN_q     <= cfgN_d;
            cfgK_q     <= cfgK_d;
            flushCnt_q <= flushCnt_d;
            outIdx_q   <= outIdx_d;
            feedDly_q  <= feedDly_d;
        end
    end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gemm_tile_sequencer
// Self-checking bench for gemm_tile_sequencer. A cycle-level job model
// (tile index, position within tile, drain index) predicts every output on
// each falling edge; directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gemm_tile_sequencer;

    localparam int A_BITS = 16;
    localparam int B_BITS = 14;
    localparam int D_BITS = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [D_BITS-1:0] cfgM = '0;
    logic [D_BITS-1:0] cfgN = '0;
    logic [D_BITS-1:0] cfgK = '0;
    logic              outReady = 1'b1;

    logic              busy, done, err, rdEn, accClear, feedValid, feedZero, outValid;
    logic [A_BITS-1:0] aAddr;
    logic [B_BITS-1:0] bAddr;
    logic [3:0]        outIdx;
    logic [D_BITS-1:0] outMb, outNb;

    int nVectors = 0;
    int nMiscompares = 0;
    int cycleNo = 0;
    int startCyc = 0;

    gemm_tile_sequencer #(
        .A_ADDR_BITS (A_BITS),
        .B_ADDR_BITS (B_BITS),
        .DIM_BITS    (D_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_m      (cfgM),
        .cfg_n      (cfgN),
        .cfg_k      (cfgK),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_en      (rdEn),
        .a_addr     (aAddr),
        .b_addr     (bAddr),
        .acc_clear  (accClear),
        .feed_valid (feedValid),
        .feed_zero  (feedZero),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_idx    (outIdx),
        .out_mb     (outMb),
        .out_nb     (outNb)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to time-stamp observed events.
    always @(posedge clk) cycleNo <= cycleNo + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nVectors++;
        if (actual != expected) begin
            nMiscompares++;
            if (nMiscompares <= 40)
                $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d",
                         name, cycleNo, actual, expected);
        end
    endtask

    // Event logs filled by the monitor and inspected by the directed scenarios.
    int  clearCyc[$], rdCyc[$], rdA[$], rdB[$], firstA[$], firstB[$];
    int  zeroCyc[$], drainCyc[$], tileMb[$], tileNb[$], doneCyc[$];
    int  errCnt = 0;
    int  busyCnt = 0;
    bit  wantFirst = 1'b0;

    function automatic int qAt(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clearLogs();
        clearCyc.delete(); rdCyc.delete(); rdA.delete(); rdB.delete();
        firstA.delete(); firstB.delete(); zeroCyc.delete(); drainCyc.delete();
        tileMb.delete(); tileNb.delete(); doneCyc.delete();
        errCnt = 0;
        busyCnt = 0;
        wantFirst = 1'b0;
    endtask

    // Job model: a job is a sequence of tiles t = 0..M*N-1 in row-major order.
    // Within a tile, position c counts cycles: c=0 clear, c=1..K reads,
    // c=2..K+7 array shifts (zeros for c>=K+2), c>=K+8 drain of 16 results.
    typedef enum {M_IDLE, M_RUN, M_FIN} mode_e;
    mode_e mMode = M_IDLE;
    int    mM = 0, mN = 0, mK = 0, mTile = 0, mCyc = 0, mIdx = 0;
    bit    mPristine = 1'b1;

    always @(negedge clk) begin
        int  eBusy, eDone, eErr, eRd, eClr, eFv, eFz, eOv, eA, eB, eMb, eNb;
        bit  allZero;
        eBusy = 0; eDone = 0; eErr = 0; eRd = 0; eClr = 0; eFv = 0; eFz = 0; eOv = 0;
        eA = 0; eB = 0; eMb = 0; eNb = 0;
        allZero = 1'b0;

        if (!rst_n) begin
            allZero = 1'b1;
        end else begin
            case (mMode)
                M_IDLE: begin
                    eErr = int'(start && (cfgM == 0 || cfgN == 0 || cfgK == 0));
                    allZero = mPristine;
                end
                M_RUN: begin
                    eBusy = 1;
                    eMb  = mTile / mN;
                    eNb  = mTile % mN;
                    eClr = int'(mCyc == 0);
                    eRd  = int'(mCyc >= 1 && mCyc <= mK);
                    eFv  = int'(mCyc >= 2 && mCyc <= mK + 7);
                    eFz  = int'(mCyc >= mK + 2 && mCyc <= mK + 7);
                    eOv  = int'(mCyc >= mK + 8);
                    eA   = (eMb * mK + mCyc - 1) & ((1 << A_BITS) - 1);
                    eB   = (eNb * mK + mCyc - 1) & ((1 << B_BITS) - 1);
                end
                default: begin
                    eBusy = 1;
                    eDone = 1;
                end
            endcase
        end

        checkOutput("busy", int'(busy), eBusy);
        checkOutput("done", int'(done), eDone);
        checkOutput("err", int'(err), eErr);
        checkOutput("rd_en", int'(rdEn), eRd);
        checkOutput("acc_clear", int'(accClear), eClr);
        checkOutput("feed_valid", int'(feedValid), eFv);
        checkOutput("feed_zero", int'(feedZero), eFz);
        checkOutput("out_valid", int'(outValid), eOv);
        if (eRd != 0) begin
            checkOutput("a_addr", int'(aAddr), eA);
            checkOutput("b_addr", int'(bAddr), eB);
        end
        if (eOv != 0) begin
            checkOutput("out_idx", int'(outIdx), mIdx);
            checkOutput("out_mb", int'(outMb), eMb);
            checkOutput("out_nb", int'(outNb), eNb);
        end
        if (allZero) begin
            checkOutput("a_addr_zero", int'(aAddr), 0);
            checkOutput("b_addr_zero", int'(bAddr), 0);
            checkOutput("out_idx_zero", int'(outIdx), 0);
            checkOutput("out_mb_zero", int'(outMb), 0);
            checkOutput("out_nb_zero", int'(outNb), 0);
        end

        if (rst_n) begin
            if (accClear) begin clearCyc.push_back(cycleNo); wantFirst = 1'b1; end
            if (rdEn) begin
                rdCyc.push_back(cycleNo);
                rdA.push_back(int'(aAddr));
                rdB.push_back(int'(bAddr));
                if (wantFirst) begin
                    firstA.push_back(int'(aAddr));
                    firstB.push_back(int'(bAddr));
                    wantFirst = 1'b0;
                end
            end
            if (feedZero) zeroCyc.push_back(cycleNo);
            if (outValid) drainCyc.push_back(cycleNo);
            if (outValid && outReady && outIdx == 4'd0) begin
                tileMb.push_back(int'(outMb));
                tileNb.push_back(int'(outNb));
            end
            if (done) doneCyc.push_back(cycleNo);
            if (err) errCnt++;
            if (busy) busyCnt++;
        end

        if (!rst_n) begin
            mMode = M_IDLE;
            mPristine = 1'b1;
        end else begin
            case (mMode)
                M_IDLE: begin
                    if (start && cfgM != 0 && cfgN != 0 && cfgK != 0) begin
                        mMode = M_RUN;
                        mM = int'(cfgM); mN = int'(cfgN); mK = int'(cfgK);
                        mTile = 0; mCyc = 0; mIdx = 0;
                        mPristine = 1'b0;
                    end
                end
                M_RUN: begin
                    if (mCyc < mK + 8) begin
                        mCyc++;
                    end else if (outReady) begin
                        if (mIdx == 15) begin
                            if (mTile == mM * mN - 1) begin
                                mMode = M_FIN;
                            end else begin
                                mTile++;
                                mCyc = 0;
                                mIdx = 0;
                            end
                        end else begin
                            mIdx++;
                        end
                    end
                end
                default: mMode = M_IDLE;
            endcase
        end
    end

    task automatic applyStimulus(input int m, input int n, input int k);
        @(posedge clk); #1;
        cfgM = D_BITS'(m);
        cfgN = D_BITS'(n);
        cfgK = D_BITS'(k);
        start = 1'b1;
        startCyc = cycleNo;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitForDone(input int maxCyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCyc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("done_seen", int'(seen), 1);
        @(posedge clk); #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        bit found;

        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_rd_en", int'(rdEn), 0);
        checkOutput("rst_a_addr", int'(aAddr), 0);
        checkOutput("rst_out_idx", int'(outIdx), 0);
        checkOutput("rst_out_valid", int'(outValid), 0);
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] minimal job m=1 n=1 k=3");
        clearLogs();
        applyStimulus(1, 1, 3);
        waitForDone(100);
        checkOutput("min_clear_cnt", clearCyc.size(), 1);
        checkOutput("min_clear_cyc", qAt(clearCyc, 0) - startCyc, 1);
        checkOutput("min_rd_cnt", rdCyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("min_rd_cyc", qAt(rdCyc, i) - startCyc, 2 + i);
            checkOutput("min_rd_a", qAt(rdA, i), i);
            checkOutput("min_rd_b", qAt(rdB, i), i);
        end
        checkOutput("min_zero_cnt", zeroCyc.size(), 6);
        checkOutput("min_zero_first", qAt(zeroCyc, 0) - startCyc, 6);
        checkOutput("min_zero_last", qAt(zeroCyc, 5) - startCyc, 11);
        checkOutput("min_drain_cnt", drainCyc.size(), 16);
        checkOutput("min_drain_first", qAt(drainCyc, 0) - startCyc, 12);
        checkOutput("min_drain_last", qAt(drainCyc, 15) - startCyc, 27);
        checkOutput("min_done_cyc", qAt(doneCyc, 0) - startCyc, 28);

        $display("[TB] tile walk m=2 n=2 k=4");
        clearLogs();
        applyStimulus(2, 2, 4);
        waitForDone(300);
        idleCycles(3);
        checkOutput("walk_tiles", tileMb.size(), 4);
        for (int t = 0; t < 4; t++) begin
            checkOutput("walk_mb", qAt(tileMb, t), t / 2);
            checkOutput("walk_nb", qAt(tileNb, t), t % 2);
            checkOutput("walk_first_a", qAt(firstA, t), (t / 2) * 4);
            checkOutput("walk_first_b", qAt(firstB, t), (t % 2) * 4);
        end
        checkOutput("walk_done_cnt", doneCyc.size(), 1);
        checkOutput("walk_done_cyc", qAt(doneCyc, 0) - startCyc, 113);

        $display("[TB] backpressure m=1 n=1 k=2");
        clearLogs();
        applyStimulus(1, 1, 2);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (outValid && outIdx == 4'd7) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checkOutput("bp_reach_idx7", int'(found), 1);
        outReady = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_hold_idx", int'(outIdx), 7);
            checkOutput("bp_hold_valid", int'(outValid), 1);
        end
        @(posedge clk); #1;
        outReady = 1'b1;
        waitForDone(100);
        checkOutput("bp_drain_cycles", drainCyc.size(), 21);
        checkOutput("bp_done_cyc", qAt(doneCyc, 0) - startCyc, 32);

        $display("[TB] zero dimension");
        clearLogs();
        applyStimulus(1, 1, 0);
        idleCycles(4);
        applyStimulus(0, 2, 2);
        idleCycles(4);
        checkOutput("zero_err_cnt", errCnt, 2);
        checkOutput("zero_busy_cnt", busyCnt, 0);
        checkOutput("zero_rd_cnt", rdCyc.size(), 0);

        $display("[TB] start while busy");
        clearLogs();
        applyStimulus(1, 2, 3);
        @(posedge clk); #1;
        cfgM = 16'd3;
        cfgN = 16'd3;
        cfgK = 16'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitForDone(200);
        checkOutput("busy_rd_cnt", rdCyc.size(), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput("busy_rd_a", qAt(rdA, i), i % 3);
            checkOutput("busy_rd_b", qAt(rdB, i), i);
        end
        checkOutput("busy_done_cnt", doneCyc.size(), 1);
        checkOutput("busy_done_cyc", qAt(doneCyc, 0) - startCyc, 55);
        checkOutput("busy_err_cnt", errCnt, 0);

        $display("[TB] reset during flush");
        clearLogs();
        applyStimulus(1, 2, 3);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (feedZero && outNb == 16'd1) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checkOutput("rst_reach_flush", int'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_feed_valid", int'(feedValid), 0);
        checkOutput("arst_feed_zero", int'(feedZero), 0);
        checkOutput("arst_b_addr", int'(bAddr), 0);
        checkOutput("arst_out_nb", int'(outNb), 0);
        checkOutput("arst_done", int'(done), 0);
        idleCycles(2);
        rst_n = 1'b1;
        idleCycles(3);
        checkOutput("arst_no_done", doneCyc.size(), 0);
        clearLogs();
        applyStimulus(1, 1, 1);
        waitForDone(100);
        checkOutput("after_rst_done_cyc", qAt(doneCyc, 0) - startCyc, 26);
        checkOutput("after_rst_rd_a", qAt(rdA, 0), 0);
        idleCycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/gemm_tile_sequencer.md
# gemm_tile_sequencer

Control sequencer for the CFU's 4x4 int8 systolic GEMM datapath. It walks an M×N grid of 4×4 output tiles, issues A (image) and B (kernel) global-buffer read addresses for every K step, and drives the array's feed, zero-flush and accumulator-clear controls. It then drains the 16 accumulators of each tile to the CPU-response path through a valid/ready handshake. It replaces the ad-hoc `start_count` / `img_size` / `ker_size` counter logic with one FSM.

## Interface
Parameters:
- A_ADDR_BITS, 16, width of the A buffer index
- B_ADDR_BITS, 14, width of the B buffer index
- DIM_BITS, 16, width of each dimension config field

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_m  in  DIM_BITS  number of 4-row A blocks
- cfg_n  in  DIM_BITS  number of 4-column B blocks
- cfg_k  in  DIM_BITS  reduction depth, in packed words
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last tile drains
- err  out  1  one-cycle pulse when start is seen with a zero dimension
- rd_en  out  1  buffer read strobe
- a_addr  out  A_ADDR_BITS  A buffer read index
- b_addr  out  B_ADDR_BITS  B buffer read index
- acc_clear  out  1  clears all 16 accumulators
- feed_valid  out  1  array shifts this cycle
- feed_zero  out  1  with feed_valid: inject zeros instead of buffer data
- out_valid  out  1  result index presented
- out_ready  in  1  consumer accepts the result
- out_idx  out  4  accumulator index, 0..15, row-major
- out_mb, out_nb  out  DIM_BITS each  tile coordinates of the current drain

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- IDLE, start=1:
  - Any cfg field zero: pulse err, remain in IDLE.
  - Otherwise: latch cfg, set mb=nb=0, go to CLEAR. Config changes after acceptance are ignored.
- CLEAR: acc_clear=1 for one cycle. Load kc=0, a_addr=a_base, b_addr=b_base. Go to FEED.
- FEED:
  - rd_en=1 for exactly cfg_k cycles; a_addr and b_addr increment by 1 each cycle.
  - After the cycle with kc==cfg_k-1, go to FLUSH.
- FLUSH: 7 cycles.
  - Cycle 0: feed_valid=1, feed_zero=0, for the last word's read latency.
  - Cycles 1–6: feed_valid=1, feed_zero=1. This is the 2·(4−1) skew drain.
  - Then go to DRAIN.
- feed_valid in FEED equals rd_en delayed one cycle. The buffer returns data one cycle after the address.
- DRAIN:
  - out_valid=1 with out_idx starting at 0. out_idx advances on each out_valid&out_ready.
  - The handshake at out_idx=15 completes the tile:
    - If nb<cfg_n-1: nb++, b_base+=cfg_k, go to CLEAR.
    - Else if mb<cfg_m-1: nb=0, b_base=0, mb++, a_base+=cfg_k, go to CLEAR.
    - Else go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Address layout:
  - a_addr = mb·cfg_k + kc and b_addr = nb·cfg_k + kc.
  - Computed with running base registers only; no multiplier.
  - Overflow wraps modulo 2^bits and is not flagged.

## Timing
- Reset values: state IDLE; all outputs 0; out_idx, a_addr, b_addr, out_mb, out_nb all 0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced. The next start begins a fresh job.
- Cycles per tile with out_ready held high: 1 + cfg_k + 7 + 16.
- A start pulse while busy is ignored.
- With out_ready low, out_valid and out_idx hold stable.
- out_valid never drops without a handshake.
- feed_valid, rd_en and acc_clear are never asserted in DRAIN.
- out_mb and out_nb are stable for the whole drain.

## Structure
- Shared package `gemm_pkg`:
  - state enum;
  - ARRAY_DIM=4;
  - FLUSH_CYCLES=7;
  - OUT_IDX_BITS=4.
- One natural sub-module, `tile_addr_gen`: holds kc, the mb/nb counters and the a_base/b_base registers. It exposes a_addr, b_addr, last_k and last_tile to the FSM.

## Test plan
- Minimal job:
  - Stimulus: cfg m=1, n=1, k=3; start at cycle 0.
  - acc_clear at cycle 1.
  - rd_en at cycles 2–4 with a_addr/b_addr 0,1,2.
  - feed_zero at cycles 6–11.
  - out_idx 0..15 at cycles 12–27.
  - done at cycle 28.
- Tile walk:
  - Stimulus: m=2, n=2, k=4.
  - Tile order: (0,0), (0,1), (1,0), (1,1).
  - b_addr first values per tile: 0, 4, 0, 4.
  - a_addr first values per tile: 0, 0, 4, 4.
  - Exactly one done pulse.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles at out_idx=7.
  - out_idx stays 7 and out_valid stays 1 throughout; drain resumes when ready returns.
- Zero dimension:
  - Stimulus: start with k=0.
  - err pulses for one cycle, busy stays 0, no rd_en.
- Start while busy:
  - Stimulus: second start mid-FEED with different cfg.
  - Ignored; the first job's addresses are unchanged.
- Reset mid-operation:
  - Stimulus: rst_n low during FLUSH.
  - All outputs 0 asynchronously, no done pulse.
  - A subsequent m=1, n=1, k=1 job completes in 25 cycles.
